microsequencer: RTL
===================

# microsequencer

Sequences the microcode for the CPU. It holds the T-state counter and drives the microcode ROM address from the current opcode and T-state. It presents each 16-bit microinstruction to the control decoder. It also supplies the fixed two-step fetch, honours the RT (reset T-state) bit, stalls on slow device transfers, and provides run/halt/single-step control for the front panel.

## Interface
Parameters:
- FETCH0, 16'h0040, T0 microinstruction: PC out (bus_out=0), MAR in (bus_in=1).
- FETCH1, 16'h3480, T1 microinstruction: RAM out (bus_out=3), IR in (bus_in=2), P+.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- opcode  in  8  IR high byte, held stable by the datapath from T2 onward.
- rom_data  in  16  microcode ROM output, combinational from rom_addr.
- dev_ready  in  1  device handshake; low stalls any cycle whose uinstr asserts DI or DO.
- run  in  1  level; 1 = free-run, 0 = halt at next instruction boundary.
- step  in  1  one-cycle pulse; from HALT, executes exactly one instruction.
- rom_addr  out  11  {opcode, tstate}.
- uinstr  out  16  current microinstruction to the control decoder.
- tstate  out  3  current T-state.
- halted  out  1  state == HALT.
- instr_start  out  1  high during any executing T0 cycle.

## Operation
- FSM states: HALT, RUN, STEP. Reset value: HALT, tstate=0.
- uinstr by state and T-state:
  - HALT: 16'h0000. PC drives the bus with no consumer, so this cycle is harmless.
  - T0: FETCH0. T1: FETCH1.
  - T2..T7: rom_data.
- rom_addr always = {opcode, tstate}. ROM entries at T0/T1 are don't-care.
- Decode on uinstr:
  - rt = ~uinstr[15] & uinstr[11].
  - devx = (uinstr[8:6]==3'd6) | (~uinstr[15] & uinstr[14:12]==3'd6).
- stall = devx & ~dev_ready. advance = (state != HALT) & ~stall.
- next_t = 0 if rt or tstate==7, else tstate+1. On advance, tstate <= next_t. On stall, tstate and uinstr are held unchanged.
- boundary = advance & (next_t == 0).
- Transitions:
  - HALT: run=1 -> RUN. Else step=1 -> STEP. Else stay.
  - RUN: boundary & ~run -> HALT. Otherwise stay; dropping run mid-instruction finishes the instruction.
  - STEP: boundary -> (run ? RUN : HALT).
  - step pulses in RUN or STEP are ignored. run=1 and step=1 together in HALT -> RUN.
- instr_start = (state != HALT) & tstate==0.
- halted = (state == HALT).
- RT at T0 or T1 is impossible: the fetch words have bit 11 clear.
- RT during T7 behaves the same as the T7 wrap.

## Timing
- Registered state: FSM state and tstate only. All outputs are combinational from registers plus opcode, rom_data and dev_ready. There is no extra pipeline stage.
- Each microinstruction executes in the cycle it is presented. The T-state update is visible on the next rising edge.
- Cycle counts:
  - Minimum instruction: 3 cycles (T0, T1, T2 with RT).
  - Maximum: 8 cycles plus stalls.
- HALT -> RUN: the first T0 executes on the cycle after the edge that samples run=1.
- Stall: any number of cycles. Release is on the edge where dev_ready=1, which completes the device cycle.
- Reset asserted mid-instruction: immediately HALT, tstate=0, uinstr=0, halted=1. After release, the first clock with run=1 enters RUN and starts from T0.

## Test plan
- Reset then run=1, opcode=8'h12, ROM[{12,2}]=16'h0840 (RT set) -> uinstr sequence 0040, 3480, 0840, then 0040 again; rom_addr at T2 = 11'h092.
- opcode with no RT and ROM words 16'h0100 at T2..T7 -> tstate 0..7 wraps to 0 after 8 cycles; instr_start pulses every 8 cycles.
- ROM T2 word has bus_in=6 (DI), dev_ready low for 3 cycles -> tstate stays 2 and uinstr is held 4 cycles total; tstate advances on the edge where dev_ready=1.
- run dropped at T3 of a 5-step instruction -> T4 completes, then halted=1, uinstr=0000, tstate=0.
- In HALT, step pulse -> exactly one instruction (T0..RT), then halted=1. A second step pulse mid-instruction has no effect.
- reset_n pulsed low at T5 asynchronously, without a clock edge -> tstate=0, halted=1 and uinstr=0000 immediately.

Source files
------------

// File: rtl/microsequencer.sv
// Microcode sequencer: tracks the T-state, forms the microcode ROM address,
// supplies the fixed two-word fetch, honours RT, stalls on device transfers
// and provides run / halt / single-step control for the front panel.
module microsequencer #(
    parameter logic [15:0] FETCH0 = 16'h0040,
    parameter logic [15:0] FETCH1 = 16'h3480
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  opcode,
    input  logic [15:0] rom_data,
    input  logic        dev_ready,
    input  logic        run,
    input  logic        step,
    output logic [10:0] rom_addr,
    output logic [15:0] uinstr,
    output logic [2:0]  tstate,
    output logic        halted,
    output logic        instr_start
);

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] tstate_q, tstate_d;

    logic       rt;
    logic       devx;
    logic       stall;
    logic       advance;
    logic [2:0] next_t;
    logic       boundary;

    // Register the control state and T-state; reset drops straight to HALT at T0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_HALT;
            tstate_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            tstate_q <= tstate_d;
        end
    end

    // Select the current microinstruction and decode RT / device-transfer bits.
    always_comb begin
        uinstr = 16'h0000;
        if (state_q != ST_HALT) begin
            case (tstate_q)
                3'd0:    uinstr = FETCH0;
                3'd1:    uinstr = FETCH1;
                default: uinstr = rom_data;
            endcase
        end
        rt       = ~uinstr[15] & uinstr[11];
        devx     = (uinstr[8:6] == 3'd6) | (~uinstr[15] & (uinstr[14:12] == 3'd6));
        stall    = devx & ~dev_ready;
        advance  = (state_q != ST_HALT) & ~stall;
        next_t   = (rt || tstate_q == 3'd7) ? 3'd0 : tstate_q + 3'd1;
        boundary = advance & (next_t == 3'd0);
    end

    // Next T-state and run/halt/step transitions; a stall freezes everything.
    always_comb begin
        state_d  = state_q;
        tstate_d = advance ? next_t : tstate_q;
        case (state_q)
            ST_HALT: begin
                if (run) begin
                    state_d = ST_RUN;
                end else if (step) begin
                    state_d = ST_STEP;
                end
            end
            ST_RUN: begin
                if (boundary && !run) begin
                    state_d = ST_HALT;
                end
            end
            ST_STEP: begin
                if (boundary) begin
                    state_d = run ? ST_RUN : ST_HALT;
                end
            end
            default: begin
                state_d  = ST_HALT;
                tstate_d = 3'd0;
            end
        endcase
    end

    // Status outputs derived directly from the registered state.
    always_comb begin
        rom_addr    = {opcode, tstate_q};
        tstate      = tstate_q;
        halted      = (state_q == ST_HALT);
        instr_start = (state_q != ST_HALT) && (tstate_q == 3'd0);
    end

endmodule
